// File: rtl/hemaia_clk_update_sequencer_if.sv
// Handshake bundle between the clock/reset register file (master) and the
// clock update sequencer (slave); per-channel pulses, division values and divider controls.
interface hemaia_clk_update_sequencer_if #(
    parameter int unsigned NumClocks        = 4,
    parameter int unsigned MaxDivisionWidth = 8
);
    logic                                  test_mode_i;
    logic [NumClocks-1:0]                  div_req_i;
    logic [NumClocks-1:0]                  rst_req_i;
    logic [NumClocks*MaxDivisionWidth-1:0] div_value_i;
    logic [NumClocks-1:0]                  clk_en_o;
    logic [NumClocks*MaxDivisionWidth-1:0] div_value_o;
    logic [NumClocks-1:0]                  div_load_o;
    logic [NumClocks-1:0]                  rst_no;
    logic                                  busy_o;
    logic [NumClocks-1:0]                  done_o;

    modport master (
        output test_mode_i, div_req_i, rst_req_i, div_value_i,
        input  clk_en_o, div_value_o, div_load_o, rst_no, busy_o, done_o
    );

    modport slave (
        input  test_mode_i, div_req_i, rst_req_i, div_value_i,
        output clk_en_o, div_value_o, div_load_o, rst_no, busy_o, done_o
    );
endinterface

// File: rtl/hemaia_clk_update_sequencer.sv
// Serialises per-channel divider updates and domain resets (gate, load, settle, ungate, reset hold).
// Grant to done: 1 + 2*GateSettleCycles + 1 + ResetHoldCycles + 1 cycles; no backpressure, requests queue as pending bits.
module hemaia_clk_update_sequencer #(
    parameter int unsigned NumClocks        = 4,
    parameter int unsigned MaxDivisionWidth = 8,
    parameter logic [MaxDivisionWidth-1:0] DefaultDivision [NumClocks] = '{default: MaxDivisionWidth'(1)},
    parameter int unsigned GateSettleCycles = 4,
    parameter int unsigned ResetHoldCycles  = 16
) (
    input logic                          mst_clk_after_pll,
    input logic                          mst_rst_ni,
    hemaia_clk_update_sequencer_if.slave bus
);
    localparam int unsigned SelW   = (NumClocks > 1) ? $clog2(NumClocks) : 1;
    localparam int unsigned MaxCnt = (GateSettleCycles > ResetHoldCycles) ? GateSettleCycles : ResetHoldCycles;
    localparam int unsigned CntW   = $clog2(MaxCnt + 1);

    typedef logic [SelW-1:0]             sel_t;
    typedef logic [MaxDivisionWidth-1:0] div_t;

    localparam logic [CntW-1:0] GateLast = CntW'(GateSettleCycles - 1);
    localparam logic [CntW-1:0] HoldLast = CntW'(ResetHoldCycles - 1);
    localparam sel_t            LastSel  = SelW'(NumClocks - 1);

    typedef enum logic [2:0] {INIT, IDLE, GATE, LOAD, SETTLE, RST_HOLD, DONE} state_e;

    state_e               state_q;
    logic [CntW-1:0]      cnt_q;
    sel_t                 sel_q;
    sel_t                 rr_q;
    logic                 do_rst_q;
    div_t                 latch_q;
    logic [NumClocks-1:0] pend_div_q;
    logic [NumClocks-1:0] pend_rst_q;
    logic [NumClocks-1:0] clk_en_q;
    div_t                 div_q [NumClocks];
    logic [NumClocks-1:0] div_load_q;
    logic [NumClocks-1:0] rst_n_q;
    logic                 busy_q;
    logic [NumClocks-1:0] done_q;

    logic [NumClocks-1:0] pend_any;
    logic                 grant_vld;
    sel_t                 grant_sel;
    sel_t                 cand;
    int                   idx;
    div_t                 grant_value;
    logic [NumClocks-1:0] clr;

    assign pend_any = pend_div_q | pend_rst_q;

    // Round-robin: first pending channel at or after rr_q, wrapping.
    always_comb begin
        grant_vld = 1'b0;
        grant_sel = '0;
        cand      = '0;
        idx       = 0;
        for (int k = 0; k < int'(NumClocks); k++) begin
            idx  = (int'(rr_q) + k) % int'(NumClocks);
            cand = sel_t'(idx);
            if (!grant_vld && pend_any[cand]) begin
                grant_vld = 1'b1;
                grant_sel = cand;
            end
        end
    end

    assign grant_value = bus.div_value_i[int'(grant_sel)*MaxDivisionWidth +: MaxDivisionWidth];

    always_comb begin
        clr = '0;
        if (state_q == IDLE && grant_vld) begin
            clr[grant_sel] = 1'b1;
        end
    end

    always_ff @(posedge mst_clk_after_pll or negedge mst_rst_ni) begin
        if (!mst_rst_ni) begin
            state_q    <= INIT;
            cnt_q      <= '0;
            sel_q      <= '0;
            rr_q       <= '0;
            do_rst_q   <= 1'b0;
            latch_q    <= '0;
            pend_div_q <= '0;
            pend_rst_q <= '0;
            clk_en_q   <= '1;
            div_load_q <= '0;
            rst_n_q    <= '0;
            busy_q     <= 1'b1;
            done_q     <= '0;
            for (int i = 0; i < int'(NumClocks); i++) begin
                div_q[i] <= DefaultDivision[i];
            end
        end else begin
            // A new pulse wins over the grant clear so it re-arms the channel.
            pend_div_q <= (pend_div_q & ~clr) | bus.div_req_i;
            pend_rst_q <= (pend_rst_q & ~clr) | bus.rst_req_i;
            div_load_q <= '0;
            done_q     <= '0;
            case (state_q)
                INIT: begin
                    if (cnt_q == HoldLast) begin
                        cnt_q   <= '0;
                        rst_n_q <= '1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                IDLE: begin
                    if (grant_vld) begin
                        sel_q    <= grant_sel;
                        do_rst_q <= pend_rst_q[grant_sel];
                        latch_q  <= (grant_value == '0) ? MaxDivisionWidth'(1) : grant_value;
                        rr_q     <= (grant_sel == LastSel) ? '0 : grant_sel + 1'b1;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        if (pend_rst_q[grant_sel]) begin
                            rst_n_q[grant_sel] <= 1'b0;
                        end
                        if (pend_div_q[grant_sel]) begin
                            clk_en_q[grant_sel] <= 1'b0;
                            state_q             <= GATE;
                        end else begin
                            state_q <= RST_HOLD;
                        end
                    end
                end
                GATE: begin
                    if (cnt_q == GateLast) begin
                        cnt_q             <= '0;
                        div_load_q[sel_q] <= 1'b1;
                        state_q           <= LOAD;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                LOAD: begin
                    div_q[sel_q] <= latch_q;
                    state_q      <= SETTLE;
                end
                SETTLE: begin
                    if (cnt_q == GateLast) begin
                        cnt_q           <= '0;
                        clk_en_q[sel_q] <= 1'b1;
                        if (do_rst_q) begin
                            state_q <= RST_HOLD;
                        end else begin
                            done_q[sel_q] <= 1'b1;
                            state_q       <= DONE;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RST_HOLD: begin
                    if (cnt_q == HoldLast) begin
                        cnt_q          <= '0;
                        rst_n_q[sel_q] <= 1'b1;
                        done_q[sel_q]  <= 1'b1;
                        state_q        <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= INIT;
            endcase
        end
    end

    assign bus.clk_en_o   = clk_en_q | {NumClocks{bus.test_mode_i}};
    assign bus.div_load_o = div_load_q;
    assign bus.rst_no     = rst_n_q;
    assign bus.busy_o     = busy_q;
    assign bus.done_o     = done_q;

    for (genvar i = 0; i < int'(NumClocks); i++) begin : g_div_out
        assign bus.div_value_o[i*MaxDivisionWidth +: MaxDivisionWidth] = div_q[i];
    end
endmodule

// File: tb/tb_hemaia_clk_update_sequencer.sv
// Directed bench for the clock update sequencer: power-up, division, division+reset,
// round-robin order, re-arm/collapse, test mode, abort and request latching during INIT.
module tb_hemaia_clk_update_sequencer;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    hemaia_clk_update_sequencer_if #(.NumClocks(4), .MaxDivisionWidth(8)) bus ();

    hemaia_clk_update_sequencer #(
        .NumClocks(4), .MaxDivisionWidth(8), .GateSettleCycles(4), .ResetHoldCycles(16)
    ) dut (
        .mst_clk_after_pll(clk),
        .mst_rst_ni       (rst_n),
        .bus              (bus)
    );

    task automatic stepn(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    int         rr_order [4] = '{2, 3, 0, 1};
    logic [3:0] one;
    int         done0, done3, first0, second0;

    initial begin
        bus.test_mode_i = 1'b0;
        bus.div_req_i   = '0;
        bus.rst_req_i   = '0;
        bus.div_value_i = '0;
        stepn(2);
        chk("reset_rst_no", bus.rst_no, 4'b0000);
        chk("reset_clk_en", bus.clk_en_o, 4'b1111);
        chk("reset_div_value", bus.div_value_o, 32'h01010101);
        chk("reset_busy", bus.busy_o, 1'b1);
        chk("reset_load", bus.div_load_o, 4'b0000);
        chk("reset_done", bus.done_o, 4'b0000);

        // Power-up: rst_no held 16 cycles after release.
        rst_n = 1'b1;
        stepn(15);
        chk("init_hold_rst_no", bus.rst_no, 4'b0000);
        chk("init_hold_busy", bus.busy_o, 1'b1);
        stepn(1);
        chk("init_release_rst_no", bus.rst_no, 4'b1111);
        chk("init_release_busy", bus.busy_o, 1'b0);

        // Single division on channel 2 to 5.
        bus.div_value_i = 32'h00050000;
        bus.div_req_i   = 4'b0100;
        stepn(1);
        bus.div_req_i = '0;
        stepn(1);
        chk("div_gate_clk_en", bus.clk_en_o, 4'b1011);
        chk("div_gate_busy", bus.busy_o, 1'b1);
        stepn(3);
        chk("div_gate_end_clk_en", bus.clk_en_o, 4'b1011);
        chk("div_gate_end_load", bus.div_load_o, 4'b0000);
        stepn(1);
        chk("div_load_strobe", bus.div_load_o, 4'b0100);
        chk("div_load_old_value", bus.div_value_o, 32'h01010101);
        chk("div_load_rst_no", bus.rst_no, 4'b1111);
        stepn(1);
        chk("div_settle_load", bus.div_load_o, 4'b0000);
        chk("div_settle_value", bus.div_value_o, 32'h01050101);
        stepn(3);
        chk("div_settle_end_clk_en", bus.clk_en_o, 4'b1011);
        stepn(1);
        chk("div_done_clk_en", bus.clk_en_o, 4'b1111);
        chk("div_done_pulse", bus.done_o, 4'b0100);
        chk("div_done_rst_no", bus.rst_no, 4'b1111);
        stepn(1);
        chk("div_idle_busy", bus.busy_o, 1'b0);
        chk("div_idle_done", bus.done_o, 4'b0000);

        // Division + reset on channel 1 with value 0 (replaced by 1).
        bus.div_req_i = 4'b0010;
        bus.rst_req_i = 4'b0010;
        stepn(1);
        bus.div_req_i = '0;
        bus.rst_req_i = '0;
        stepn(1);
        chk("dr_gate_clk_en", bus.clk_en_o, 4'b1101);
        chk("dr_gate_rst_no", bus.rst_no, 4'b1101);
        stepn(5);
        chk("dr_zero_value", bus.div_value_o, 32'h01050101);
        stepn(4);
        chk("dr_ungate_clk_en", bus.clk_en_o, 4'b1111);
        chk("dr_ungate_rst_no", bus.rst_no, 4'b1101);
        stepn(15);
        chk("dr_hold_end_rst_no", bus.rst_no, 4'b1101);
        chk("dr_hold_end_done", bus.done_o, 4'b0000);
        stepn(1);
        chk("dr_done_rst_no", bus.rst_no, 4'b1111);
        chk("dr_done_pulse", bus.done_o, 4'b0010);
        stepn(1);
        chk("dr_idle_busy", bus.busy_o, 1'b0);

        // Round-robin after last grant 1: order 2,3,0,1.
        bus.div_value_i = 32'h03060709;
        bus.div_req_i   = 4'b1111;
        stepn(1);
        bus.div_req_i = '0;
        for (int k = 0; k < 4; k++) begin
            one = 4'b0001 << rr_order[k];
            stepn(1);
            chk("rr_gate_clk_en", bus.clk_en_o, 4'b1111 ^ one);
            stepn(9);
            chk("rr_done_pulse", bus.done_o, one);
            stepn(1);
        end
        chk("rr_idle_busy", bus.busy_o, 1'b0);
        chk("rr_values", bus.div_value_o, 32'h03060709);

        // Collapse during channel 3's sequence, then re-arm in channel 0's grant cycle.
        bus.div_value_i = 32'h04060709;
        bus.div_req_i   = 4'b1000;
        done0 = 0; done3 = 0; first0 = 0; second0 = 0;
        for (int c = 1; c <= 45; c++) begin
            stepn(1);
            bus.div_req_i = (c == 3 || c == 5 || c == 7 || c == 12) ? 4'b0001 : 4'b0000;
            if (bus.done_o[0]) begin
                done0++;
                if (done0 == 1) first0 = c;
                else second0 = c;
            end
            if (bus.done_o[3]) done3++;
        end
        chk("rearm_ch3_services", done3, 1);
        chk("rearm_ch0_services", done0, 2);
        chk("rearm_first_done_cycle", first0, 22);
        chk("rearm_second_done_cycle", second0, 33);
        chk("rearm_idle_busy", bus.busy_o, 1'b0);
        chk("rearm_values", bus.div_value_o, 32'h04060709);

        // Test mode during GATE, then async reset in SETTLE.
        bus.div_value_i = 32'h00080000;
        bus.div_req_i   = 4'b0100;
        stepn(1);
        bus.div_req_i = '0;
        stepn(2);
        bus.test_mode_i = 1'b1;
        #1;
        chk("tm_gate_clk_en", bus.clk_en_o, 4'b1111);
        stepn(3);
        chk("tm_load_strobe", bus.div_load_o, 4'b0100);
        chk("tm_load_clk_en", bus.clk_en_o, 4'b1111);
        stepn(1);
        bus.test_mode_i = 1'b0;
        #1;
        chk("tm_off_clk_en", bus.clk_en_o, 4'b1011);
        stepn(1);
        rst_n = 1'b0;
        #1;
        chk("abort_clk_en", bus.clk_en_o, 4'b1111);
        chk("abort_rst_no", bus.rst_no, 4'b0000);
        chk("abort_div_value", bus.div_value_o, 32'h01010101);
        chk("abort_load", bus.div_load_o, 4'b0000);
        chk("abort_busy", bus.busy_o, 1'b1);
        chk("abort_done", bus.done_o, 4'b0000);

        // Restart from INIT; a reset request during INIT is latched and served afterwards.
        stepn(1);
        rst_n = 1'b1;
        stepn(3);
        bus.rst_req_i = 4'b0001;
        stepn(1);
        bus.rst_req_i = '0;
        stepn(12);
        chk("reinit_release_rst_no", bus.rst_no, 4'b1111);
        chk("reinit_release_busy", bus.busy_o, 1'b0);
        stepn(1);
        chk("latched_rst_rst_no", bus.rst_no, 4'b1110);
        chk("latched_rst_clk_en", bus.clk_en_o, 4'b1111);
        chk("latched_rst_busy", bus.busy_o, 1'b1);
        stepn(15);
        chk("latched_rst_hold_end", bus.rst_no, 4'b1110);
        stepn(1);
        chk("latched_rst_done_rst_no", bus.rst_no, 4'b1111);
        chk("latched_rst_done_pulse", bus.done_o, 4'b0001);
        stepn(1);
        chk("latched_rst_idle_busy", bus.busy_o, 1'b0);
        chk("latched_rst_values", bus.div_value_o, 32'h01010101);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
